// File: rtl/pll_phase_ctrl_pkg.sv
// rtl/pll_phase_ctrl_pkg.sv - shared types and constants for the PLL phase controller
// Package pll_ctrl_pkg: FSM states, PSDA width, fixed duty code, counter sizing.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_LOCKED,
    ST_SETTLE,
    ST_FAULT
  } state_t;

  localparam int          PSDA_W         = 4;
  localparam logic [3:0]  DUTYDA_DEFAULT = 4'b1000;

  // One counter is shared by every timed state, so it must hold the largest interval.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// rtl/pll_phase_ctrl_if.sv - request/status interface between calibration logic and the controller
// Absolute-set signals exist only when PLL_PHASE_CTRL_ABS_SET_EN is defined.
interface pll_phase_ctrl_if;
  import pll_ctrl_pkg::*;

  logic              step_req;
  logic              step_dir;
  logic              step_ack;
  logic              ready;
  logic              fault;
  logic [1:0]        retry_cnt;
`ifdef PLL_PHASE_CTRL_ABS_SET_EN
  logic              set_req;
  logic [PSDA_W-1:0] set_val;

  modport master (output step_req, step_dir, set_req, set_val,
                  input  step_ack, ready, fault, retry_cnt);
  modport slave  (input  step_req, step_dir, set_req, set_val,
                  output step_ack, ready, fault, retry_cnt);
`else
  modport master (output step_req, step_dir,
                  input  step_ack, ready, fault, retry_cnt);
  modport slave  (input  step_req, step_dir,
                  output step_ack, ready, fault, retry_cnt);
`endif

endinterface

// File: rtl/pll_phase_ctrl_lock_sync.sv
// rtl/pll_phase_ctrl_lock_sync.sv - two-flop synchronizer for the asynchronous PLL lock
// Resets to 0 so a stale lock never survives a controller reset.
module lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - rPLL reset/lock supervisor and dynamic phase (PSDA) owner
// Optional absolute phase load enabled by PLL_PHASE_CTRL_ABS_SET_EN.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_WAIT_CYCLES = 4096,
  parameter int SETTLE_CYCLES    = 64,
  parameter int MAX_RETRIES      = 3
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [PSDA_W-1:0] psda,
  output logic [3:0]        dutyda,
  pll_phase_ctrl_if.slave   ctl
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_WAIT_CYCLES, SETTLE_CYCLES);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] ACK_AT      = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nx;
  logic [1:0]        r_retry;
  logic [1:0]        w_retry_nx;
  logic [1:0]        w_retry_inc;
  logic [PSDA_W-1:0] r_psda;
  logic [PSDA_W-1:0] w_psda_nx;
  logic [PSDA_W-1:0] r_psda_prev;
  logic [PSDA_W-1:0] w_prev_nx;
  logic              w_ack_nx;
  logic              r_ack;
  logic              r_pll_reset;
  logic              r_ready;
  logic              r_fault;
  logic              w_lock_s;
  logic              w_set_req;
  logic [PSDA_W-1:0] w_set_val;

  lock_sync u_lock_sync (
    .clk     (clkin),
    .rst     (reset),
    .i_async (pll_lock),
    .o_sync  (w_lock_s)
  );

`ifdef PLL_PHASE_CTRL_ABS_SET_EN
  assign w_set_req = ctl.set_req;
  assign w_set_val = ctl.set_val;
`else
  assign w_set_req = 1'b0;
  assign w_set_val = '0;
`endif

  assign w_retry_inc = r_retry + 2'd1;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CW'(1);
    w_retry_nx = r_retry;
    w_psda_nx  = r_psda;
    w_prev_nx  = r_psda_prev;
    w_ack_nx   = 1'b0;
    case (r_state)
      ST_RST_PLL: begin
        if (r_cnt == RST_LAST) begin
          w_state_nx = ST_WAIT_LOCK;
          w_cnt_nx   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nx = ST_LOCKED;
          w_cnt_nx   = '0;
          w_retry_nx = 2'd0;
        end else if (r_cnt == LOCK_LAST) begin
          w_cnt_nx   = '0;
          w_retry_nx = w_retry_inc;
          w_state_nx = (w_retry_inc == RETRY_MAX) ? ST_FAULT : ST_RST_PLL;
        end
      end
      ST_LOCKED: begin
        w_cnt_nx = '0;
        if (!w_lock_s) begin
          w_state_nx = ST_RST_PLL;
        end else if (w_set_req) begin
          w_prev_nx  = r_psda;
          w_psda_nx  = w_set_val;
          w_state_nx = ST_SETTLE;
        end else if (ctl.step_req) begin
          w_prev_nx  = r_psda;
          w_psda_nx  = ctl.step_dir ? r_psda + 4'd1 : r_psda - 4'd1;
          w_state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Once the ack cycle is reached the change is committed; only earlier losses undo it.
        if (!w_lock_s) begin
          w_state_nx = ST_RST_PLL;
          w_cnt_nx   = '0;
          if (r_cnt != SETTLE_LAST) w_psda_nx = r_psda_prev;
        end else if (r_cnt == ACK_AT) begin
          w_ack_nx = 1'b1;
        end else if (r_cnt == SETTLE_LAST) begin
          w_state_nx = ST_LOCKED;
          w_cnt_nx   = '0;
        end
      end
      ST_FAULT: begin
        w_cnt_nx = '0;
      end
      default: begin
        w_state_nx = ST_RST_PLL;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state <= ST_RST_PLL;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_cnt       <= '0;
      r_retry     <= 2'd0;
      r_psda      <= '0;
      r_psda_prev <= '0;
      r_ack       <= 1'b0;
      r_pll_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nx;
      r_retry     <= w_retry_nx;
      r_psda      <= w_psda_nx;
      r_psda_prev <= w_prev_nx;
      r_ack       <= w_ack_nx;
      r_pll_reset <= (w_state_nx == ST_RST_PLL) || (w_state_nx == ST_FAULT);
      r_ready     <= (w_state_nx == ST_LOCKED);
      r_fault     <= (w_state_nx == ST_FAULT);
    end
  end

  assign pll_reset     = r_pll_reset;
  assign psda          = r_psda;
  assign dutyda        = DUTYDA_DEFAULT;
  assign ctl.step_ack  = r_ack;
  assign ctl.ready     = r_ready;
  assign ctl.fault     = r_fault;
  assign ctl.retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb/tb_pll_phase_ctrl.sv - self-checking bench for pll_phase_ctrl
// Timestamp-based reference model plus directed literal checks and a randomized soak.
module tb_pll_phase_ctrl;

  localparam int RSTP = 4;
  localparam int LW   = 32;
  localparam int ST   = 8;
  localparam int MR   = 2;

  localparam int M_RST = 0, M_WAIT = 1, M_LOCK = 2, M_SET = 3, M_FLT = 4;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [3:0] psda;
  logic [3:0] dutyda;

  pll_phase_ctrl_if ctl ();

  pll_phase_ctrl #(
    .RST_PULSE_CYCLES (RSTP),
    .LOCK_WAIT_CYCLES (LW),
    .SETTLE_CYCLES    (ST),
    .MAX_RETRIES      (MR)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .psda      (psda),
    .dutyda    (dutyda),
    .ctl       (ctl)
  );

  always #5 clkin = ~clkin;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each mode remembers the cycle it was entered; timing follows from elapsed age.
  int         m_mode = M_RST;
  int         m_enter = 0;
  int         m_retry = 0;
  int         m_age;
  logic [3:0] m_psda = 4'd0;
  logic [3:0] m_prev = 4'd0;
  logic       m_ack = 1'b0;
  logic       m_h1 = 1'b0, m_h2 = 1'b0, m_used;
  logic       m_set;

  always @(posedge clkin) begin
    cyc = cyc + 1;
    if (reset) begin
      m_mode = M_RST; m_enter = cyc; m_retry = 0;
      m_psda = 4'd0; m_prev = 4'd0; m_ack = 1'b0; m_h1 = 1'b0; m_h2 = 1'b0;
    end else begin
      m_used = m_h2; m_h2 = m_h1; m_h1 = pll_lock;
      m_age  = cyc - m_enter - 1;
      m_ack  = 1'b0;
`ifdef PLL_PHASE_CTRL_ABS_SET_EN
      m_set = ctl.set_req;
`else
      m_set = 1'b0;
`endif
      case (m_mode)
        M_RST: if (m_age == RSTP - 1) begin m_mode = M_WAIT; m_enter = cyc; end
        M_WAIT: begin
          if (m_used) begin
            m_mode = M_LOCK; m_enter = cyc; m_retry = 0;
          end else if (m_age == LW - 1) begin
            m_retry = m_retry + 1;
            m_mode  = (m_retry == MR) ? M_FLT : M_RST;
            m_enter = cyc;
          end
        end
        M_LOCK: begin
          if (!m_used) begin
            m_mode = M_RST; m_enter = cyc;
          end else if (m_set) begin
`ifdef PLL_PHASE_CTRL_ABS_SET_EN
            m_prev = m_psda; m_psda = ctl.set_val; m_mode = M_SET; m_enter = cyc;
`endif
          end else if (ctl.step_req) begin
            m_prev = m_psda;
            m_psda = 4'((int'(m_psda) + (ctl.step_dir ? 1 : 15)) % 16);
            m_mode = M_SET; m_enter = cyc;
          end
        end
        M_SET: begin
          if (!m_used) begin
            if (m_age < ST) m_psda = m_prev;
            m_mode = M_RST; m_enter = cyc;
          end else if (m_age == ST - 1) begin
            m_ack = 1'b1;
          end else if (m_age == ST) begin
            m_mode = M_LOCK; m_enter = cyc;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clkin) begin
    if (cyc > 0) begin
      chk("mdl_pll_reset", pll_reset, (m_mode == M_RST) || (m_mode == M_FLT));
      chk("mdl_ready", ctl.ready, m_mode == M_LOCK);
      chk("mdl_fault", ctl.fault, m_mode == M_FLT);
      chk("mdl_retry_cnt", ctl.retry_cnt, m_retry);
      chk("mdl_psda", psda, m_psda);
      chk("mdl_step_ack", ctl.step_ack, m_ack);
      chk("mdl_dutyda", dutyda, 4'b1000);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clkin); #2; end
  endtask

  task automatic do_step(input bit dir, output int lat, output bit ok);
    logic [3:0] old;
    int c_p, c_a;
    @(posedge clkin); #2;
    old = psda; c_p = -1; c_a = -1;
    ctl.step_dir = dir; ctl.step_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clkin);
      if (c_p < 0 && psda !== old) c_p = cyc;
      if (ctl.step_ack === 1'b1) begin c_a = cyc; break; end
    end
    @(posedge clkin); #2;
    ctl.step_req = 1'b0;
    ok  = (c_a >= 0);
    lat = c_a - c_p;
  endtask

  // Keeps the request held through a lock loss, relocks once pll_reset drops, then finishes the handshake.
  task automatic ride_out(output bit saw, output logic [3:0] p_at_rst, output int acks_pre, output int acks);
    bit relocked;
    saw = 0; relocked = 0; acks = 0; acks_pre = 0; p_at_rst = 4'd0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clkin);
      if (ctl.step_ack === 1'b1) acks++;
      if (pll_reset && !saw) begin saw = 1; p_at_rst = psda; acks_pre = acks; end
      if (saw && !pll_reset && !relocked) begin relocked = 1; pll_lock = 1'b1; end
      if (ctl.step_ack === 1'b1) break;
    end
    @(posedge clkin); #2;
    ctl.step_req = 1'b0;
  endtask

  initial begin
    int n, lat, acks, acks_pre;
    bit ok, got, saw, last_ack;
    int low_left;
    logic [3:0] p_rst;
    logic tr[90];
    logic [1:0] rc[90];

    ctl.step_req = 1'b0; ctl.step_dir = 1'b0;
`ifdef PLL_PHASE_CTRL_ABS_SET_EN
    ctl.set_req = 1'b0; ctl.set_val = 4'd0;
`endif
    reset = 1'b1; pll_lock = 1'b0;
    tick(3);
    reset = 1'b0;
    chk("rst_pll_reset", pll_reset, 1); chk("rst_psda", psda, 0);
    chk("rst_ready", ctl.ready, 0);     chk("rst_fault", ctl.fault, 0);
    chk("rst_retry", ctl.retry_cnt, 0); chk("rst_ack", ctl.step_ack, 0);
    chk("rst_dutyda", dutyda, 8);

    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clkin);
      if (pll_reset) n++; else break;
    end
    chk("nom_reset_width", n, 4);
    repeat (9) @(posedge clkin);
    #2 pll_lock = 1'b1;
    n = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clkin); n++;
      @(negedge clkin);
      if (ctl.ready) begin got = 1; break; end
    end
    chk("nom_ready_seen", got, 1);
    chk("nom_lock_latency", n, 3);
    chk("nom_retry", ctl.retry_cnt, 0);

    do_step(1'b0, lat, ok);
    chk("wrap_dn_ack", ok, 1); chk("wrap_dn_psda", psda, 15); chk("wrap_dn_lat", lat, 8);
    chk("wrap_dn_ready", ctl.ready, 1);
    do_step(1'b1, lat, ok);
    chk("wrap_up_ack", ok, 1); chk("wrap_up_psda", psda, 0); chk("wrap_up_lat", lat, 8);
    chk("wrap_up_ready", ctl.ready, 1);
    do_step(1'b0, lat, ok);
    chk("wrap_dn2_psda", psda, 15);
    for (int k = 0; k < 4; k++) do_step(1'b1, lat, ok);
    chk("pre_loss_psda", psda, 3);

    @(posedge clkin); #2;
    ctl.step_dir = 1'b1; ctl.step_req = 1'b1;
    tick(1);
    chk("loss_new_psda", psda, 4);
    tick(4);
    pll_lock = 1'b0;
    ride_out(saw, p_rst, acks_pre, acks);
    chk("loss_rst_seen", saw, 1); chk("loss_restore", p_rst, 3);
    chk("loss_noack", acks_pre, 0); chk("loss_one_ack", acks, 1);
    chk("loss_final_psda", psda, 4);

    @(posedge clkin); #2 pll_lock = 1'b0;
    tick(2);
    ctl.step_dir = 1'b1; ctl.step_req = 1'b1;
    @(posedge clkin); @(negedge clkin);
    chk("race_rst", pll_reset, 1); chk("race_psda", psda, 4); chk("race_ready", ctl.ready, 0);
    ride_out(saw, p_rst, acks_pre, acks);
    chk("race_one_ack", acks, 1); chk("race_final_psda", psda, 5);

`ifdef PLL_PHASE_CTRL_ABS_SET_EN
    @(posedge clkin); #2;
    ctl.set_val = 4'd9; ctl.set_req = 1'b1; ctl.step_dir = 1'b1; ctl.step_req = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkin);
      if (ctl.step_ack) begin got = 1; break; end
    end
    chk("set_ack", got, 1); chk("set_psda", psda, 9);
    @(posedge clkin); #2 ctl.set_req = 1'b0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkin);
      if (ctl.step_ack) begin got = 1; break; end
    end
    chk("set_then_step_ack", got, 1); chk("set_then_step_psda", psda, 10);
    @(posedge clkin); #2 ctl.step_req = 1'b0;
`endif

    last_ack = 0; low_left = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clkin); last_ack = ctl.step_ack;
      @(posedge clkin); #2;
      if (i == 800) reset = 1'b1;
      if (i == 802) reset = 1'b0;
      if (pll_lock && $urandom_range(0, 99) == 0) begin
        pll_lock = 1'b0; low_left = $urandom_range(1, 20);
      end else if (!pll_lock) begin
        low_left--;
        if (low_left <= 0) pll_lock = 1'b1;
      end
      if (ctl.step_req && last_ack) ctl.step_req = 1'b0;
      else if (!ctl.step_req && $urandom_range(0, 3) == 0) begin
        ctl.step_dir = 1'($urandom); ctl.step_req = 1'b1;
      end
    end
    ctl.step_req = 1'b0;

    reset = 1'b1; pll_lock = 1'b0;
    tick(3);
    reset = 1'b0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clkin); tr[i] = pll_reset; rc[i] = ctl.retry_cnt;
    end
    n = 0;
    for (int i = 0; i < 72; i++) if (tr[i]) n++;
    chk("flt_reset_cycles", n, 8);
    chk("flt_gap_end", tr[35], 0); chk("flt_pulse2_start", tr[36], 1);
    chk("flt_pulse2_end", tr[39], 1); chk("flt_gap2_start", tr[40], 0);
    chk("flt_retry1", rc[40], 1); chk("flt_retry2", rc[72], 2);
    n = 0;
    for (int i = 72; i < 90; i++) if (tr[i]) n++;
    chk("flt_reset_steady", n, 18);
    chk("flt_fault", ctl.fault, 1); chk("flt_ready", ctl.ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
